output_rr_mux: RTL and testbench

//  Round-robin burst multiplexer that merges NUM_CH 16-bit result streams from the

---
 rtl/output_rr_mux.sv | 167 ++++++++++++++++
 tb/tb_output_rr_mux.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/output_rr_mux.sv
// Round-robin burst multiplexer: NUM_CH sample streams -> one registered valid/ready stream.
// Define OUT_MUX_TLAST_EN to add the data_out_last frame-end marker.
module output_rr_mux #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned FRAME_LEN = 256
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        start,
    input  logic [NUM_CH*DATA_W-1:0]    ch_data,
    input  logic [NUM_CH-1:0]           ch_valid,
    output logic [NUM_CH-1:0]           ch_ready,
    output logic [DATA_W-1:0]           data_out,
    output logic                        data_out_valid,
`ifdef OUT_MUX_TLAST_EN
    output logic                        data_out_last,
`endif
    input  logic                        data_out_ready,
    output logic [$clog2(NUM_CH)-1:0]   grant_ch,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int unsigned GW = $clog2(NUM_CH);
    localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned WW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BW-1:0] BurstLast = BW'(BURST_LEN - 1);
    localparam logic [WW-1:0] WordLast  = WW'(FRAME_LEN - 1);
    localparam logic [GW-1:0] ChLast    = GW'(NUM_CH - 1);

    typedef enum logic [1:0] {StIdle, StArb, StXfer, StDrain} state_e;

    state_e              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       last_q, last_d;
    logic [BW-1:0]       burst_q, burst_d;
    logic [WW-1:0]       word_q, word_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dvld_q, dvld_d;
    logic                dlast_q, dlast_d;

    logic                pick_found;
    logic [GW-1:0]       pick_ch;
    logic [GW-1:0]       cand;
    logic                out_free;
    logic                accept;
    logic [DATA_W-1:0]   sel_data;

    // First valid channel strictly after the last grant, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = last_q;
        cand       = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = GW'((int'(last_q) + i) % NUM_CH);
            if (!pick_found && ch_valid[cand]) begin
                pick_found = 1'b1;
                pick_ch    = cand;
            end
        end
    end

    assign out_free = !dvld_q || data_out_ready;
    assign sel_data = ch_data[DATA_W*int'(grant_q) +: DATA_W];

    always_comb begin
        ch_ready = '0;
        if (state_q == StXfer && out_free) begin
            ch_ready[grant_q] = 1'b1;
        end
    end

    assign accept = ch_valid[grant_q] && ch_ready[grant_q];

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        burst_d    = burst_q;
        word_d     = word_q;
        dout_d     = dout_q;
        dvld_d     = dvld_q;
        dlast_d    = dlast_q;
        frame_done = 1'b0;

        if (accept) begin
            dout_d  = sel_data;
            dvld_d  = 1'b1;
            dlast_d = (word_q == WordLast);
        end else if (data_out_ready) begin
            dvld_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StArb;
            end
            StArb: begin
                if (pick_found) begin
                    grant_d = pick_ch;
                    last_d  = pick_ch;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (accept) begin
                    if (burst_q == BurstLast) begin
                        burst_d = '0;
                        if (word_q == WordLast) begin
                            state_d = StDrain;
                        end else begin
                            word_d  = word_q + 1'b1;
                            state_d = StArb;
                        end
                    end else begin
                        burst_d = burst_q + 1'b1;
                        word_d  = word_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (out_free) begin
                    frame_done = 1'b1;
                    word_d     = '0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= ChLast;
            burst_q <= '0;
            word_q  <= '0;
            dout_q  <= '0;
            dvld_q  <= 1'b0;
            dlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            word_q  <= word_d;
            dout_q  <= dout_d;
            dvld_q  <= dvld_d;
            dlast_q <= dlast_d;
        end
    end

    assign data_out       = dout_q;
    assign data_out_valid = dvld_q;
    assign grant_ch       = grant_q;
    assign busy           = (state_q != StIdle);
`ifdef OUT_MUX_TLAST_EN
    assign data_out_last  = dlast_q;
`else
    logic unused_dlast;
    assign unused_dlast = dlast_q;
`endif

endmodule

// File: tb/tb_output_rr_mux.sv
// Scoreboard bench for output_rr_mux: NUM_CH=4, BURST_LEN=4, FRAME_LEN=16.
module tb_output_rr_mux;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int BL  = 4;
    localparam int FL  = 16;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              start = 1'b0;
    logic [NCH*DW-1:0] ch_data = '0;
    logic [NCH-1:0]    ch_valid = '0;
    logic [NCH-1:0]    ch_ready;
    logic [DW-1:0]     data_out;
    logic              data_out_valid;
    logic              data_out_ready = 1'b1;
    logic [1:0]        grant_ch;
    logic              busy;
    logic              frame_done;
`ifdef OUT_MUX_TLAST_EN
    logic              data_out_last;
`endif

    output_rr_mux #(
        .NUM_CH(NCH), .DATA_W(DW), .BURST_LEN(BL), .FRAME_LEN(FL)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .start          (start),
        .ch_data        (ch_data),
        .ch_valid       (ch_valid),
        .ch_ready       (ch_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
`ifdef OUT_MUX_TLAST_EN
        .data_out_last  (data_out_last),
`endif
        .data_out_ready (data_out_ready),
        .grant_ch       (grant_ch),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t           exp_q[$];
    int             errors = 0;
    int             checks = 0;
    int             n[NCH] = '{default: 0};
    logic [NCH-1:0] en = '0;
    logic [NCH-1:0] allowed = '0;
    bit             rnd_rdy = 0;
    bit             drop_en = 0;
    bit             dropped = 0;
    int             hold = 0;
    bit             mon_en = 0;
    int             fd_cnt = 0;
    int             mask_viol = 0;
    int             cyc = 0;
    int             first_cyc = 0;
    int             last_cyc = 0;
    int             nwords = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic drive();
        for (int c = 0; c < NCH; c++) ch_data[c*DW +: DW] = 16'(c * 256 + n[c]);
        ch_valid       = en & ~((hold > 0) ? 4'b0010 : 4'b0000);
        data_out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Source/sink model: counts source handshakes, advances per-channel sample index.
    initial begin
        logic [NCH-1:0] take;
        forever begin
            @(negedge aclk);
            take = ch_valid & ch_ready;
            @(posedge aclk);
            #1;
            for (int c = 0; c < NCH; c++) if (take[c]) n[c]++;
            if (drop_en && !dropped && n[1] == 2) begin
                hold    = 5;
                dropped = 1;
            end else if (hold > 0) begin
                hold--;
            end
            drive();
        end
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        exp_t          e;
        bit            stall_prev = 0;
        logic [DW-1:0] held = '0;
        forever begin
            @(negedge aclk);
            cyc++;
            if (frame_done) fd_cnt++;
            if (busy && ((ch_ready & ~allowed) != 0)) mask_viol++;
            if ($countones(ch_ready) > 1) mask_viol++;
            if (hold > 0 && (ch_ready[2] || (busy && grant_ch != 2'd1))) mask_viol++;
            if (stall_prev && data_out_valid) chk("stall_hold", 32'(data_out), 32'(held));
            stall_prev = data_out_valid && !data_out_ready;
            held       = data_out;
            if (mon_en && data_out_valid && data_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", 32'(data_out), 32'(e.d));
`ifdef OUT_MUX_TLAST_EN
                    chk("last", 32'(data_out_last), 32'(e.l));
`endif
                end
                if (nwords == 0) first_cyc = cyc;
                last_cyc = cyc;
                nwords++;
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, " dout_valid"}, 32'(data_out_valid), 0);
        chk({tag, " dout"}, 32'(data_out), 0);
        chk({tag, " ch_ready"}, 32'(ch_ready), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " grant_ch"}, 32'(grant_ch), 0);
        chk({tag, " frame_done"}, 32'(frame_done), 0);
    endtask

    task automatic run_frame(input string tag, input logic [NCH-1:0] ena, input bit rnd,
                             input bit drop, input int order[4]);
        int   cnt_e[NCH];
        int   t;
        exp_t e;
        @(posedge aclk);
        #2;
        en = ena; allowed = ena; rnd_rdy = rnd; drop_en = drop; dropped = 0; hold = 0;
        n = '{default: 0}; cnt_e = '{default: 0};
        fd_cnt = 0; mask_viol = 0; nwords = 0; mon_en = 1;
        for (int b = 0; b < FL / BL; b++) begin
            for (int k = 0; k < BL; k++) begin
                e.d = 16'(order[b] * 256 + cnt_e[order[b]]);
                e.l = (b * BL + k == FL - 1);
                cnt_e[order[b]]++;
                exp_q.push_back(e);
            end
        end
        drive();
        start = 1'b1;
        @(posedge aclk);
        #2;
        start = 1'b0;
        t = 0;
        while (fd_cnt == 0 && t < 2000) begin
            @(negedge aclk);
            t++;
        end
        repeat (3) @(negedge aclk);
        chk({tag, " frame_done_cnt"}, 32'(fd_cnt), 1);
        chk({tag, " queue_empty"}, 32'(exp_q.size()), 0);
        chk({tag, " words"}, 32'(nwords), 32'(FL));
        chk({tag, " busy_after"}, 32'(busy), 0);
        chk({tag, " ready_mask"}, 32'(mask_viol), 0);
        @(posedge aclk);
        #2;
        en = '0; rnd_rdy = 0; drop_en = 0;
        exp_q.delete();
        drive();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive();
        repeat (3) @(negedge aclk);
        check_reset_state("por");
        @(posedge aclk);
        #2;
        aresetn = 1'b1;

        // Abort a frame mid-burst with reset.
        @(posedge aclk);
        #2;
        en = 4'hF; allowed = 4'hF; n = '{default: 0}; mon_en = 0;
        drive();
        start = 1'b1;
        @(posedge aclk);
        #2;
        start = 1'b0;
        repeat (4) @(posedge aclk);
        #2;
        chk("pre_reset busy", 32'(busy), 1);
        aresetn = 1'b0;
        @(negedge aclk);
        check_reset_state("mid_reset");
        @(posedge aclk);
        #2;
        aresetn = 1'b1;
        en = '0;
        drive();
        repeat (2) @(posedge aclk);

        run_frame("all_valid", 4'hF, 0, 0, '{0, 1, 2, 3});
        chk("all_valid span", 32'(last_cyc - first_cyc), 32'(18));
        run_frame("only_ch2", 4'b0100, 0, 0, '{2, 2, 2, 2});
        chk("only_ch2 grant", 32'(grant_ch), 2);
        run_frame("rand_ready", 4'hF, 1, 0, '{3, 0, 1, 2});
        run_frame("ch1_drop", 4'b0110, 0, 1, '{1, 2, 1, 2});
        chk("ch1_drop happened", 32'(dropped), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
